wb_bank_buffer: RTL and testbench
=================================

# wb_bank_buffer

Double-banked frame buffer that sits directly downstream of the Wishbone-classic prefetcher. It accepts the prefetcher's transmit-bus writes into a "fill" bank and presents the previously completed frame on a second, read-only Wishbone-classic slave port for the host-side reader. On `swap_i`, driven by the prefetcher's `ready_o`, the banks exchange roles, so the reader always sees a complete, stable frame while the next one is being filled.

## Interface
- `WIDTH`, 32: data word width.
- `SBITS`, 10: word-address width per bank; each bank holds 2^SBITS words.
- `COUNT`, 576: words per frame; reading address COUNT-1 marks the frame consumed.
- `clk_i`  in  1  system clock; all logic on the rising edge.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `swap_i`  in  1  one-cycle pulse: fill bank complete, exchange banks.
- `w_cyc_i`, `w_stb_i`, `w_we_i`  in  1 each  fill-port Wishbone classic controls.
- `w_adr_i`  in  SBITS  fill word address.
- `w_dat_i`  in  WIDTH  fill write data.
- `w_ack_o`  out  1  fill-port acknowledge.
- `r_cyc_i`, `r_stb_i`, `r_we_i`  in  1 each  read-port Wishbone classic controls.
- `r_adr_i`  in  SBITS  read word address.
- `r_dat_o`  out  WIDTH  read data.
- `r_ack_o`  out  1  read-port acknowledge.
- `valid_o`  out  1  read bank holds an unconsumed frame.
- `overrun_o`  out  1  sticky: a swap arrived while the frame was unconsumed.

## Operation
- Storage: 2×2^SBITS words, one synchronous-read RAM, addressed `{bank, adr}`. The register `wsel` selects the fill bank; the read bank is `!wsel`.
- Fill port is write-only. A request (`cyc&stb`) with `we=1` writes `w_dat_i` to `{wsel, w_adr_i}` on the acking edge. A request with `we=0` is acked with no effect.
- Read port is read-only for RAM. A request with `we=0` reads `{!wsel, r_adr_i}`. A request with `we=1` is acked, writes nothing, and clears `overrun_o`.
- Ack generation, both ports: `ack <= cyc & stb & !ack`. This gives one ack pulse per transfer. A master holding `stb` after its ack gets a new ack every second cycle.
- Swap on `swap_i`:
  - `wsel` toggles.
  - `valid_o` is set to 1.
  - If `valid_o` was already 1 and no consuming read lands that cycle, `overrun_o` is set to 1.
- Consume: a read-port read ack with `r_adr_i == COUNT-1` while `valid_o=1` clears `valid_o`. When `valid_o=0`, the read still returns data and changes no state. Addresses ≥ COUNT are readable and never consume.
- Simultaneous swap and consuming read: the read returns old read-bank data, `valid_o` ends at 1, and `overrun_o` is unchanged.
- Fill bank is latched at request. A write acked in the same cycle as `swap_i` lands in the pre-swap fill bank.
- Reset mid-operation: all state clears immediately. RAM contents are not cleared. In-flight transfers are dropped without ack.

## Timing
- Reset values: `w_ack_o=0`, `r_ack_o=0`, `r_dat_o=0`, `valid_o=0`, `overrun_o=0`, `wsel=0`.
- Fill write: request at cycle N; `w_ack_o=1` in N+1; the RAM is written at the N+1 edge.
- Read: request at cycle N; `r_ack_o=1` and `r_dat_o` valid in N+1. `r_dat_o` holds its value until the next read ack.
- `swap_i` at edge N: the new roles and `valid_o` are visible in N+1. A read request in N+1 sees the new read bank.
- The two ports are fully independent. Both may ack in the same cycle; they never collide, because they always address different banks.

## Configuration
- Macro `WB_BANK_BUFFER_OVERRUN_EN`, when defined:
  - Overrun protection is compiled in.
  - A swap while `valid_o=1` with no simultaneous consume is suppressed: `wsel` is unchanged, the unread frame is kept, and the new frame will be overwritten by the next fill.
  - `overrun_o` is set; a read-port write clears it.
- When undefined:
  - `overrun_o` is tied to 0.
  - Every `swap_i` toggles `wsel` unconditionally; unconsumed frames are silently replaced.

## Test plan
- Reset: hold `rst_ni=0` asynchronously mid-transfer -> all outputs 0 on the same cycle; after release the first fill goes to bank 0.
- Fill/swap/read: write 0x1000+i to addresses 0..575, pulse `swap_i`, then read addresses 0..575 -> `r_dat_o=0x1000+i`, one `r_ack_o` per read, and `valid_o` falls after the read of address 575.
- Write-in-swap-cycle: the last fill ack coincides with `swap_i` -> that word appears in the new read bank; the next fill goes to the other bank.
- Simultaneous consume and swap: read address 575 in the same cycle as `swap_i` -> `valid_o` stays 1, `overrun_o` stays 0.
- Overrun, macro defined: two swaps with no reads in between -> `overrun_o=1`, the read bank still returns frame 1 data; a read-port write clears `overrun_o`.
- Overrun, macro undefined: same stimulus -> `overrun_o=0`, the read bank returns frame 2 data.

Source files
------------

// File: rtl/wb_bank_buffer_if.sv
// Bus bundle for wb_bank_buffer: a write-only fill port and a read-only
// reader port, both Wishbone classic.
interface wb_bank_buffer_if #(
   parameter int WIDTH = 32,
   parameter int SBITS = 10
);
   // Handshake: a transfer is requested while cyc & stb are high; the slave
   // answers with a one-cycle ack on the next edge, and the transfer completes
   // on that edge. A master still holding stb after ack is answered again one
   // cycle later, so the ack never stays high for two consecutive cycles.
   logic             w_cyc_i;
   logic             w_stb_i;
   logic             w_we_i;
   logic [SBITS-1:0] w_adr_i;
   logic [WIDTH-1:0] w_dat_i;
   logic             w_ack_o;

   logic             r_cyc_i;
   logic             r_stb_i;
   logic             r_we_i;
   logic [SBITS-1:0] r_adr_i;
   logic [WIDTH-1:0] r_dat_o;
   logic             r_ack_o;

   modport master (
      output w_cyc_i, w_stb_i, w_we_i, w_adr_i, w_dat_i,
      input  w_ack_o,
      output r_cyc_i, r_stb_i, r_we_i, r_adr_i,
      input  r_dat_o, r_ack_o
   );

   modport slave (
      input  w_cyc_i, w_stb_i, w_we_i, w_adr_i, w_dat_i,
      output w_ack_o,
      input  r_cyc_i, r_stb_i, r_we_i, r_adr_i,
      output r_dat_o, r_ack_o
   );
endinterface

// File: rtl/wb_bank_buffer.sv
// Double-banked frame buffer: prefetcher fills one bank while the host reads the other.
// Define WB_BANK_BUFFER_OVERRUN_EN to hold an unconsumed frame instead of replacing it.
module wb_bank_buffer #(
   parameter int WIDTH = 32,
   parameter int SBITS = 10,
   parameter int COUNT = 576
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              swap_i,
   wb_bank_buffer_if.slave   bus,
   output logic              valid_o,
   output logic              overrun_o
);
   localparam int DEPTH = 2 ** (SBITS + 1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic             r_wsel;
   logic             r_w_ack;
   logic             r_r_ack;
   logic [WIDTH-1:0] r_r_dat;
   logic             r_valid;

   logic             w_fill_wr;
   logic             w_rd_req;
   logic             w_rd_rd;
   logic             w_rd_clr;
   logic             w_consume;
   logic             w_swap_take;

   assign w_fill_wr = bus.w_cyc_i & bus.w_stb_i & ~r_w_ack & bus.w_we_i;
   assign w_rd_req  = bus.r_cyc_i & bus.r_stb_i & ~r_r_ack;
   assign w_rd_rd   = w_rd_req & ~bus.r_we_i;
   assign w_rd_clr  = w_rd_req & bus.r_we_i;
   assign w_consume = w_rd_rd & r_valid & (bus.r_adr_i == SBITS'(COUNT - 1));

`ifdef WB_BANK_BUFFER_OVERRUN_EN
   logic w_swap_block;
   logic r_overrun;

   // An unread frame is protected: the swap is dropped and only flagged.
   assign w_swap_block = swap_i & r_valid & ~w_consume;
   assign w_swap_take  = swap_i & ~w_swap_block;
   assign overrun_o    = r_overrun;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_overrun <= 1'b0;
      end else if (w_swap_block) begin
         r_overrun <= 1'b1;
      end else if (w_rd_clr) begin
         r_overrun <= 1'b0;
      end
   end
`else
   assign w_swap_take = swap_i;
   assign overrun_o   = 1'b0;
`endif

   // RAM contents survive reset; only the control state is cleared.
   always_ff @(posedge clk_i) begin
      if (w_fill_wr) begin
         r_mem[{r_wsel, bus.w_adr_i}] <= bus.w_dat_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wsel  <= 1'b0;
         r_w_ack <= 1'b0;
         r_r_ack <= 1'b0;
         r_r_dat <= '0;
         r_valid <= 1'b0;
      end else begin
         r_w_ack <= bus.w_cyc_i & bus.w_stb_i & ~r_w_ack;
         r_r_ack <= bus.r_cyc_i & bus.r_stb_i & ~r_r_ack;
         // Reads use the bank roles of the request cycle, so a read that
         // coincides with a swap still returns the outgoing frame.
         if (w_rd_rd) begin
            r_r_dat <= r_mem[{~r_wsel, bus.r_adr_i}];
         end
         if (w_swap_take) begin
            r_wsel  <= ~r_wsel;
            r_valid <= 1'b1;
         end else if (w_consume) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign bus.w_ack_o = r_w_ack;
   assign bus.r_ack_o = r_r_ack;
   assign bus.r_dat_o = r_r_dat;
   assign valid_o     = r_valid;
endmodule

// File: tb/tb_wb_bank_buffer.sv
// Self-checking bench for wb_bank_buffer against a two-bank behavioural model.
module tb_wb_bank_buffer;
  localparam int WIDTH = 32;
  localparam int SBITS = 10;
  localparam int COUNT = 576;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic swap = 1'b0;
  logic valid;
  logic ovr;

  always #5 clk = ~clk;

  wb_bank_buffer_if #(.WIDTH(WIDTH), .SBITS(SBITS)) bus ();

  wb_bank_buffer #(.WIDTH(WIDTH), .SBITS(SBITS), .COUNT(COUNT)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .swap_i    (swap),
    .bus       (bus),
    .valid_o   (valid),
    .overrun_o (ovr)
  );

  // ---------------- reference model ----------------
  // Two banks of words; "fill" names the bank the prefetcher writes, the
  // other one is what the reader sees.
  logic [WIDTH-1:0] m_mem [0:1][0:(1<<SBITS)-1];
  bit m_fill;
  bit m_valid;
  bit m_ovr;

  logic [WIDTH-1:0] exp_q [$];
  logic [WIDTH-1:0] exp_rdat;
  logic obs_w_ack, obs_r_ack, obs_valid, obs_ovr;
  logic [WIDTH-1:0] obs_r_dat;

  int n_vec = 0;
  int n_err = 0;

  task automatic model_reset;
    m_fill = 1'b0;
    m_valid = 1'b0;
    m_ovr = 1'b0;
    exp_rdat = '0;
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic bus_idle;
    bus.w_cyc_i = 1'b0; bus.w_stb_i = 1'b0; bus.w_we_i = 1'b0;
    bus.w_adr_i = '0;   bus.w_dat_i = '0;
    bus.r_cyc_i = 1'b0; bus.r_stb_i = 1'b0; bus.r_we_i = 1'b0;
    bus.r_adr_i = '0;
    swap = 1'b0;
  endtask

  // One transfer slot: requests launched at a falling edge, outputs sampled
  // just after the next rising edge, then everything released.
  task automatic bus_cycle(input bit do_w, input bit w_we, input logic [SBITS-1:0] wadr,
                           input logic [WIDTH-1:0] wdat, input bit do_r, input bit r_we,
                           input logic [SBITS-1:0] radr, input bit swp);
    bit consume;
    @(negedge clk);
    bus.w_cyc_i = do_w; bus.w_stb_i = do_w; bus.w_we_i = w_we;
    bus.w_adr_i = wadr; bus.w_dat_i = wdat;
    bus.r_cyc_i = do_r; bus.r_stb_i = do_r; bus.r_we_i = r_we;
    bus.r_adr_i = radr;
    swap = swp;

    consume = do_r && !r_we && m_valid && (int'(radr) == COUNT - 1);
    if (do_r && !r_we) exp_q.push_back(m_mem[!m_fill][radr]);
    if (do_w && w_we) m_mem[m_fill][wadr] = wdat;
    if (do_r && r_we) m_ovr = 1'b0;
    if (swp) begin
`ifdef WB_BANK_BUFFER_OVERRUN_EN
      if (m_valid && !consume) m_ovr = 1'b1;
      else begin
        m_fill = !m_fill;
        m_valid = 1'b1;
      end
`else
      m_fill = !m_fill;
      m_valid = 1'b1;
`endif
    end else if (consume) begin
      m_valid = 1'b0;
    end

    @(posedge clk);
    #1;
    obs_w_ack = bus.w_ack_o;
    obs_r_ack = bus.r_ack_o;
    obs_r_dat = bus.r_dat_o;
    obs_valid = valid;
    obs_ovr = ovr;
    if (do_r && !r_we) exp_rdat = exp_q.pop_front();
    @(negedge clk);
    bus_idle();
  endtask

  task automatic fill(input logic [SBITS-1:0] a, input logic [WIDTH-1:0] d);
    bus_cycle(1'b1, 1'b1, a, d, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic read(input logic [SBITS-1:0] a);
    bus_cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, a, 1'b0);
  endtask

  task automatic do_swap;
    bus_cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({bus.w_ack_o, bus.r_ack_o, valid, ovr} !== 4'b0 || bus.r_dat_o !== '0) begin
      n_err++;
      $display("FAIL reset_state got ack=%b/%b valid=%b ovr=%b dat=%h exp all 0",
               bus.w_ack_o, bus.r_ack_o, valid, ovr, bus.r_dat_o);
    end
    @(negedge clk) rst_n = 1'b1;

    fill(SBITS'(5), 32'hA5A5_0005);
    fill(SBITS'(COUNT - 1), 32'hA5A5_0240);
    do_swap();
    read(SBITS'(5));
    n_vec++;
    if (obs_r_dat !== 32'hA5A5_0005) begin
      n_err++; $display("FAIL pre_reset_read got %h exp a5a50005", obs_r_dat);
    end

    // Write into the fill bank, then pull reset while its ack is high.
    @(negedge clk);
    bus.w_cyc_i = 1'b1; bus.w_stb_i = 1'b1; bus.w_we_i = 1'b1;
    bus.w_adr_i = SBITS'(5); bus.w_dat_i = 32'hBBBB_0005;
    m_mem[m_fill][5] = 32'hBBBB_0005;
    @(posedge clk);
    #1;
    n_vec++;
    if (bus.w_ack_o !== 1'b1) begin
      n_err++; $display("FAIL pre_reset_ack got %b exp 1", bus.w_ack_o);
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({bus.w_ack_o, bus.r_ack_o, valid, ovr} !== 4'b0 || bus.r_dat_o !== '0) begin
      n_err++;
      $display("FAIL async_reset got ack=%b/%b valid=%b ovr=%b dat=%h exp all 0",
               bus.w_ack_o, bus.r_ack_o, valid, ovr, bus.r_dat_o);
    end
    model_reset();
    @(negedge clk) bus_idle();
    @(negedge clk) rst_n = 1'b1;

    fill(SBITS'(5), 32'hCCCC_0005);
    fill(SBITS'(COUNT - 1), 32'hCCCC_0240);
    do_swap();
    read(SBITS'(5));
    n_vec++;
    if (obs_r_dat !== 32'hCCCC_0005) begin
      n_err++; $display("FAIL post_reset_bank0 got %h exp cccc0005", obs_r_dat);
    end
    read(SBITS'(COUNT - 1));
    n_vec++;
    if (obs_r_dat !== 32'hCCCC_0240 || obs_valid !== 1'b0) begin
      n_err++; $display("FAIL post_reset_consume got dat=%h valid=%b exp cccc0240/0", obs_r_dat, obs_valid);
    end
  endtask

  task automatic test_fill_swap_read;
    for (int i = 0; i < COUNT; i++) begin
      fill(SBITS'(i), 32'h1000 + i);
      n_vec++;
      if (obs_w_ack !== 1'b1) begin
        n_err++; $display("FAIL fill_ack adr=%0d got %b exp 1", i, obs_w_ack);
      end
    end
    fill(SBITS'(COUNT + 3), 32'hBEEF_0003);
    do_swap();
    n_vec++;
    if (obs_valid !== 1'b1) begin
      n_err++; $display("FAIL swap_valid got %b exp 1", obs_valid);
    end
    for (int i = 0; i < COUNT - 1; i++) begin
      read(SBITS'(i));
      n_vec++;
      if (obs_r_ack !== 1'b1 || obs_r_dat !== 32'h1000 + i || obs_valid !== 1'b1) begin
        n_err++;
        $display("FAIL frame_read adr=%0d got ack=%b dat=%h valid=%b exp 1/%h/1",
                 i, obs_r_ack, obs_r_dat, obs_valid, 32'h1000 + i);
      end
    end
    read(SBITS'(COUNT + 3));
    n_vec++;
    if (obs_r_dat !== 32'hBEEF_0003 || obs_valid !== 1'b1) begin
      n_err++; $display("FAIL beyond_count got dat=%h valid=%b exp beef0003/1", obs_r_dat, obs_valid);
    end
    read(SBITS'(COUNT - 1));
    n_vec++;
    if (obs_r_dat !== 32'h1000 + COUNT - 1 || obs_valid !== 1'b0) begin
      n_err++; $display("FAIL last_read got dat=%h valid=%b exp %h/0", obs_r_dat, obs_valid, 32'h1000 + COUNT - 1);
    end
    read(SBITS'(COUNT - 1));
    n_vec++;
    if (obs_r_ack !== 1'b1 || obs_r_dat !== 32'h1000 + COUNT - 1 || obs_valid !== 1'b0) begin
      n_err++; $display("FAIL reread_invalid got ack=%b dat=%h valid=%b", obs_r_ack, obs_r_dat, obs_valid);
    end
  endtask

  task automatic test_write_in_swap;
    logic [WIDTH-1:0] d [0:9];
    logic [WIDTH-1:0] x;
    for (int i = 0; i < 10; i++) d[i] = $urandom;
    x = $urandom;
    fill(SBITS'(COUNT - 1), 32'h5A5A_0240);
    for (int i = 0; i < 9; i++) fill(SBITS'(i), d[i]);
    bus_cycle(1'b1, 1'b1, SBITS'(9), d[9], 1'b0, 1'b0, '0, 1'b1);
    n_vec++;
    if (obs_w_ack !== 1'b1 || obs_valid !== 1'b1) begin
      n_err++; $display("FAIL wis_ack got ack=%b valid=%b exp 1/1", obs_w_ack, obs_valid);
    end
    read(SBITS'(9));
    n_vec++;
    if (obs_r_dat !== d[9]) begin
      n_err++; $display("FAIL wis_last_word got %h exp %h", obs_r_dat, d[9]);
    end
    fill(SBITS'(9), x);
    read(SBITS'(9));
    n_vec++;
    if (obs_r_dat !== d[9]) begin
      n_err++; $display("FAIL wis_bank_stable got %h exp %h", obs_r_dat, d[9]);
    end
    for (int i = 0; i < 9; i++) begin
      read(SBITS'(i));
      n_vec++;
      if (obs_r_dat !== d[i]) begin
        n_err++; $display("FAIL wis_frame adr=%0d got %h exp %h", i, obs_r_dat, d[i]);
      end
    end
    read(SBITS'(COUNT - 1));
    do_swap();
    read(SBITS'(9));
    n_vec++;
    if (obs_r_dat !== x) begin
      n_err++; $display("FAIL wis_next_fill got %h exp %h", obs_r_dat, x);
    end
    read(SBITS'(COUNT - 1));
    n_vec++;
    if (obs_r_dat !== exp_rdat || obs_valid !== 1'b0) begin
      n_err++; $display("FAIL wis_consume got dat=%h valid=%b exp %h/0", obs_r_dat, obs_valid, exp_rdat);
    end
  endtask

  task automatic test_consume_swap;
    fill(SBITS'(COUNT - 1), 32'hEEEE_0001);
    do_swap();
    fill(SBITS'(COUNT - 1), 32'hFFFF_0002);
    bus_cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, SBITS'(COUNT - 1), 1'b1);
    n_vec++;
    if (obs_r_dat !== 32'hEEEE_0001 || obs_valid !== 1'b1 || obs_ovr !== 1'b0) begin
      n_err++;
      $display("FAIL consume_swap got dat=%h valid=%b ovr=%b exp eeee0001/1/0", obs_r_dat, obs_valid, obs_ovr);
    end
    read(SBITS'(COUNT - 1));
    n_vec++;
    if (obs_r_dat !== 32'hFFFF_0002 || obs_valid !== 1'b0) begin
      n_err++; $display("FAIL consume_after got dat=%h valid=%b exp ffff0002/0", obs_r_dat, obs_valid);
    end
  endtask

  task automatic test_overrun;
    logic [WIDTH-1:0] base;
    logic exp_ovr;
`ifdef WB_BANK_BUFFER_OVERRUN_EN
    base = 32'h1111_0000;
    exp_ovr = 1'b1;
`else
    base = 32'h2222_0000;
    exp_ovr = 1'b0;
`endif
    for (int i = 0; i < 4; i++) fill(SBITS'(i), 32'h1111_0000 + i);
    fill(SBITS'(COUNT - 1), 32'h1111_0240);
    do_swap();
    for (int i = 0; i < 4; i++) fill(SBITS'(i), 32'h2222_0000 + i);
    fill(SBITS'(COUNT - 1), 32'h2222_0240);
    do_swap();
    n_vec++;
    if (obs_ovr !== exp_ovr || obs_valid !== 1'b1) begin
      n_err++; $display("FAIL overrun_flag got ovr=%b valid=%b exp %b/1", obs_ovr, obs_valid, exp_ovr);
    end
    for (int i = 0; i < 4; i++) begin
      read(SBITS'(i));
      n_vec++;
      if (obs_r_dat !== base + i || obs_ovr !== exp_ovr) begin
        n_err++; $display("FAIL overrun_frame adr=%0d got dat=%h ovr=%b exp %h/%b", i, obs_r_dat, obs_ovr, base + i, exp_ovr);
      end
    end
    bus_cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, '0, 1'b0);
    n_vec++;
    if (obs_r_ack !== 1'b1 || obs_ovr !== 1'b0) begin
      n_err++; $display("FAIL overrun_clear got ack=%b ovr=%b exp 1/0", obs_r_ack, obs_ovr);
    end
    read(SBITS'(COUNT - 1));
    n_vec++;
    if (obs_r_dat !== base + 32'h240 || obs_valid !== 1'b0) begin
      n_err++; $display("FAIL overrun_consume got dat=%h valid=%b exp %h/0", obs_r_dat, obs_valid, base + 32'h240);
    end
  endtask

  task automatic test_ack_hold;
    logic [WIDTH-1:0] d0;
    logic exp_ack;
    d0 = m_mem[!m_fill][0];
    @(negedge clk);
    bus.w_cyc_i = 1'b1; bus.w_stb_i = 1'b1; bus.w_we_i = 1'b0;
    bus.w_adr_i = '0; bus.w_dat_i = 32'hDEAD_BEEF;
    bus.r_cyc_i = 1'b1; bus.r_stb_i = 1'b1; bus.r_we_i = 1'b0; bus.r_adr_i = '0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      exp_ack = (k % 2 == 0);
      n_vec++;
      if (bus.w_ack_o !== exp_ack || bus.r_ack_o !== exp_ack || bus.r_dat_o !== d0) begin
        n_err++;
        $display("FAIL ack_hold k=%0d got w=%b r=%b dat=%h exp %b/%b/%h",
                 k, bus.w_ack_o, bus.r_ack_o, bus.r_dat_o, exp_ack, exp_ack, d0);
      end
    end
    @(negedge clk) bus_idle();
    @(negedge clk);
  endtask

  task automatic test_random;
    logic [SBITS-1:0] ra;
    logic [SBITS-1:0] wa;
    bit dw;
    bit wwe;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < COUNT; i++) begin
        fill(SBITS'(i), $urandom);
        if ($urandom_range(0, 7) == 0) begin
          bus_cycle(1'b1, 1'b0, SBITS'($urandom_range(0, COUNT - 1)), $urandom, 1'b0, 1'b0, '0, 1'b0);
          n_vec++;
          if (obs_w_ack !== 1'b1) begin
            n_err++; $display("FAIL rnd_nowrite_ack got %b exp 1", obs_w_ack);
          end
        end
      end
      do_swap();
      for (int n = 0; n < 40; n++) begin
        ra = SBITS'($urandom_range(0, COUNT - 2));
        wa = SBITS'($urandom_range(0, COUNT - 1));
        dw = 1'($urandom_range(0, 1));
        wwe = 1'($urandom_range(0, 1));
        bus_cycle(dw, wwe, wa, $urandom, 1'b1, 1'b0, ra, 1'b0);
        n_vec++;
        if (obs_r_ack !== 1'b1 || obs_w_ack !== dw || obs_r_dat !== exp_rdat ||
            obs_valid !== m_valid || obs_ovr !== m_ovr) begin
          n_err++;
          $display("FAIL rnd_read adr=%0d got ack=%b/%b dat=%h valid=%b ovr=%b exp %b/1 %h %b %b",
                   ra, obs_w_ack, obs_r_ack, obs_r_dat, obs_valid, obs_ovr, dw, exp_rdat, m_valid, m_ovr);
        end
      end
      read(SBITS'(COUNT - 1));
      n_vec++;
      if (obs_r_dat !== exp_rdat || obs_valid !== m_valid) begin
        n_err++; $display("FAIL rnd_consume got dat=%h valid=%b exp %h/%b", obs_r_dat, obs_valid, exp_rdat, m_valid);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    bus_idle();
    model_reset();
    test_reset();
    test_fill_swap_read();
    test_write_in_swap();
    test_consume_swap();
    test_overrun();
    test_ack_hold();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit reached after %0d vectors", n_vec);
    $fatal(1, "time limit");
  end
endmodule
